fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage; successor to the single-cycle PC/PC+4/jump-mux path.
- Decouples the PC from instruction memory using a valid/ready request/response interface, so memory latency may vary.
- Buffers fetched instructions in a DEPTH-entry FIFO toward decode.
- Predecodes J/JAL and redirects locally; accepts branch/jump redirects from downstream and flushes.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, downstream redirect and decode-facing output.
// master = fetch unit, slave = memory/decode/branch side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;

    modport master (
        output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, J/JAL predecode, DEPTH-entry buffer to decode.
// Response -> out_valid next cycle; requests stall while buffered + inflight would exceed DEPTH.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input logic          clock,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    entry_t          mem [DEPTH];
    entry_t          head;

    logic            inflight;
    logic            req_fire;
    logic            resp_take;
    logic            pop;
    logic            is_jump;
    logic [5:0]      opcode;
    logic [1:0]      redirect_lsb_unused;

    assign inflight  = (state != S_REQ);
    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_take = (state == S_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    assign pop       = bus.out_valid && bus.out_ready;
    assign opcode    = bus.imem_resp_data[31:26];
    assign is_jump   = (opcode == 6'b000010) || (opcode == 6'b000011);
    assign head      = mem[rd_ptr];

    // Target alignment drops these bits by design.
    assign redirect_lsb_unused = bus.redirect_pc[1:0];

    // Outputs are forced low while reset is held, independent of register contents.
    assign bus.imem_req_valid = !reset && (state == S_REQ) && !bus.redirect_valid
                                && ((count + CW'(inflight)) < CW'(DEPTH));
    assign bus.imem_addr      = reset ? '0 : fetch_pc;
    assign bus.out_valid      = !reset && (count != '0);
    assign bus.out_instr      = reset ? '0 : head.instr;
    assign bus.out_pc         = reset ? '0 : head.pc;
    assign bus.out_pc_plus4   = reset ? '0 : head.pc + XLEN'(4);

    always_ff @(posedge clock) begin
        if (resp_take) begin
            mem[wr_ptr] <= '{instr: bus.imem_resp_data, pc: req_pc};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            // A response landing with the redirect retires the outstanding request.
            if (state != S_REQ) begin
                state <= bus.imem_resp_valid ? S_REQ : S_DROP;
            end
        end else begin
            if (resp_take)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(resp_take) - CW'(pop);

            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc <= fetch_pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        fetch_pc <= is_jump ? {req_pc[XLEN-1:28], bus.imem_resp_data[25:0], 2'b00}
                                            : req_pc + XLEN'(4);
                        state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_resp_valid)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with programmable latency, expected request
// addresses and expected decode-side entries held in queues.
module tb_fetch_unit;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clock;
    logic reset;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_out[$];
    logic [31:0] exp_addr[$];
    bit          pending;
    bit          dropping;
    logic [31:0] pend_addr;
    int          cd;
    int          lat;
    int          n_acc;
    int          n_out;
    bit          rd_vld;
    logic [31:0] rd_pc;
    bit          ordy;
    logic [31:0] j_addr;
    logic [31:0] j_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == j_addr) ? j_word : (32'h2000_0000 | a);
    endfunction

    // One clock: drive inputs at negedge, then observe the handshakes the next posedge will take.
    task automatic cycle();
        bit   resp_now;
        exp_t e;
        logic [31:0] a;
        @(negedge clock);
        resp_now                = pending && (cd == 0);
        bus.redirect_valid      = rd_vld;
        bus.redirect_pc         = rd_pc;
        bus.imem_resp_valid     = resp_now;
        bus.imem_resp_data      = resp_now ? mem_word(pend_addr) : 32'h0;
        bus.imem_req_ready      = (exp_addr.size() != 0);
        bus.out_ready           = ordy;
        if (pending && cd != 0) cd--;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_out.size() == 0) begin
                chk("spurious_out_vld", {31'b0, bus.out_valid}, 32'h0);
            end else begin
                e = exp_out.pop_front();
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_instr", bus.out_instr, e.instr);
                chk("out_pc_plus4", bus.out_pc_plus4, e.pc + 32'd4);
                n_out++;
            end
        end
        if (resp_now) begin
            pending = 1'b0;
            if (!rd_vld && !dropping)
                exp_out.push_back('{pc: pend_addr, instr: mem_word(pend_addr)});
            dropping = 1'b0;
        end else if (pending && rd_vld) begin
            dropping = 1'b1;
        end
        if (rd_vld) exp_out.delete();
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (pending) begin
                chk("req_while_busy", {31'b0, bus.imem_req_valid}, 32'h0);
            end else begin
                a = exp_addr.pop_front();
                chk("req_addr", bus.imem_addr, a);
                pending   = 1'b1;
                pend_addr = a;
                cd        = lat - 1;
                n_acc++;
            end
        end
    endtask

    task automatic apply_reset(input bit check_state);
        @(negedge clock);
        reset               = 1'b1;
        rd_vld              = 1'b0;
        rd_pc               = 32'h0;
        ordy                = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_req_ready  = 1'b0;
        bus.out_ready       = 1'b0;
        exp_out.delete();
        exp_addr.delete();
        pending  = 1'b0;
        dropping = 1'b0;
        n_acc    = 0;
        n_out    = 0;
        lat      = 1;
        j_addr   = 32'hFFFF_FFF0;
        j_word   = 32'h0;
        #1;
        if (check_state) begin
            chk("rst_req_vld", {31'b0, bus.imem_req_valid}, 32'h0);
            chk("rst_out_vld", {31'b0, bus.out_valid}, 32'h0);
            chk("rst_imem_addr", bus.imem_addr, 32'h0);
            chk("rst_out_instr", bus.out_instr, 32'h0);
            chk("rst_out_pc", bus.out_pc, 32'h0);
            chk("rst_out_pc4", bus.out_pc_plus4, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_idle(input string tag);
        for (int i = 0; i < 200 && (exp_addr.size() != 0 || pending || exp_out.size() != 0); i++)
            cycle();
        chk(tag, 32'(exp_addr.size() + exp_out.size()) + {31'b0, pending}, 32'h0);
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 50 && (exp_addr.size() != 0 || pending); i++)
            cycle();
        chk(tag, 32'(exp_addr.size()) + {31'b0, pending}, 32'h0);
    endtask

    task automatic wait_accept(input string tag);
        for (int i = 0; i < 50 && !pending; i++)
            cycle();
        chk(tag, {31'b0, pending}, 32'h1);
    endtask

    initial begin
        // 1: sequential fetch with single-cycle memory
        apply_reset(1'b1);
        ordy = 1'b1;
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        run_idle("t1_drain");
        chk("t1_nout", 32'(n_out), 32'd4);

        // 2: decode stalled, buffer fills to DEPTH then fetch resumes
        apply_reset(1'b0);
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        repeat (15) cycle();
        chk("t2_nacc_full", 32'(n_acc), 32'd4);
        chk("t2_req_vld_full", {31'b0, bus.imem_req_valid}, 32'h0);
        ordy = 1'b1;
        run_idle("t2_drain");
        chk("t2_nout", 32'(n_out), 32'd5);

        // 3: j and jal predecode redirect
        for (int k = 0; k < 2; k++) begin
            apply_reset(1'b0);
            j_addr = 32'h8;
            j_word = (k == 0) ? 32'h0800_0040 : 32'h0C00_0040;
            ordy = 1'b1;
            exp_addr = '{32'h0, 32'h4, 32'h8, 32'h100};
            run_idle("t3_drain");
            chk("t3_nout", 32'(n_out), 32'd4);
        end

        // 4: redirect during a slow response with two buffered entries
        apply_reset(1'b0);
        exp_addr = '{32'h0, 32'h4};
        settle("t4_fill");
        lat = 3;
        exp_addr.push_back(32'h8);
        wait_accept("t4_accept");
        rd_vld = 1'b1;
        rd_pc  = 32'h200;
        exp_addr.push_back(32'h200);
        cycle();
        rd_vld = 1'b0;
        cycle();
        chk("t4_flushed_out_vld", {31'b0, bus.out_valid}, 32'h0);
        ordy = 1'b1;
        run_idle("t4_drain");
        chk("t4_nout", 32'(n_out), 32'd1);

        // 5: unaligned redirect coincident with the response
        apply_reset(1'b0);
        ordy = 1'b1;
        exp_addr = '{32'h0};
        wait_accept("t5_accept");
        rd_vld = 1'b1;
        rd_pc  = 32'h203;
        exp_addr.push_back(32'h200);
        cycle();
        rd_vld = 1'b0;
        cycle();
        chk("t5_out_vld_after", {31'b0, bus.out_valid}, 32'h0);
        run_idle("t5_drain");
        chk("t5_nout", 32'(n_out), 32'd1);

        // 6: reset while a response is outstanding and the buffer holds two entries
        apply_reset(1'b0);
        exp_addr = '{32'h0, 32'h4};
        settle("t6_fill");
        lat = 4;
        exp_addr.push_back(32'h8);
        wait_accept("t6_accept");
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("t6_rst_out_vld", {31'b0, bus.out_valid}, 32'h0);
        chk("t6_rst_req_vld", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("t6_rst_imem_addr", bus.imem_addr, 32'h0);
        exp_out.delete();
        exp_addr.delete();
        dropping = pending;
        ordy = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 50 && pending; i++)
            cycle();
        chk("t6_stale_done", {31'b0, pending}, 32'h0);
        exp_addr.push_back(32'h0);
        run_idle("t6_drain");
        chk("t6_nout", 32'(n_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
